// File: rtl/dvi_pkg.sv
// rtl/dvi_pkg.sv - shared TMDS symbol types, control codes and helpers
package dvi_pkg;

    typedef logic [9:0]        tmds_sym_t;
    typedef logic signed [4:0] disp_t;

    localparam tmds_sym_t CTL_00 = 10'h354;
    localparam tmds_sym_t CTL_01 = 10'h0AB;
    localparam tmds_sym_t CTL_10 = 10'h154;
    localparam tmds_sym_t CTL_11 = 10'h2AB;

    function automatic tmds_sym_t ctl_symbol(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return CTL_00;
            2'b01:   return CTL_01;
            2'b10:   return CTL_10;
            default: return CTL_11;
        endcase
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/dvi_tmds_encode_if.sv
// rtl/dvi_tmds_encode_if.sv - pixel input bundle and TMDS symbol outputs
interface dvi_tmds_encode_if;
    import dvi_pkg::*;

    logic [5:0] red;
    logic [5:0] green;
    logic [5:0] blue;
    logic       hsync;
    logic       vsync;
    logic       active;
    tmds_sym_t  tmds_r;
    tmds_sym_t  tmds_g;
    tmds_sym_t  tmds_b;

    modport master (
        output red, green, blue, hsync, vsync, active,
        input  tmds_r, tmds_g, tmds_b
    );

    modport slave (
        input  red, green, blue, hsync, vsync, active,
        output tmds_r, tmds_g, tmds_b
    );
endinterface

// File: rtl/tmds_chan_enc.sv
// rtl/tmds_chan_enc.sv - one TMDS channel: input sample, 6->8 expansion, q_m stage, DC-balance stage
// Optional TMDS_SCALE_REPLICATE_EN selects full-range bit replication for the expansion.
module tmds_chan_enc
    import dvi_pkg::*;
(
    input  logic      clk_dot4x,
    input  logic      rst_n,
    input  logic [5:0] color,
    input  logic      de,
    input  logic      c0,
    input  logic      c1,
    output tmds_sym_t tmds
);

    logic [5:0] in_color;
    logic       in_de, in_c0, in_c1;
    logic [7:0] d;
    logic [3:0] n1_d;
    logic       use_xnor;
    logic [8:0] qm_next;

    logic [8:0] s1_qm;
    logic       s1_de, s1_c0, s1_c1;

    logic [3:0] n1_q;
    disp_t      diff;
    disp_t      qm8x2;
    disp_t      cnt, cnt_next;
    tmds_sym_t  sym_next;

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            in_color <= '0;
            in_de    <= 1'b0;
            in_c0    <= 1'b0;
            in_c1    <= 1'b0;
        end else begin
            in_color <= color;
            in_de    <= de;
            in_c0    <= c0;
            in_c1    <= c1;
        end
    end

`ifdef TMDS_SCALE_REPLICATE_EN
    assign d = {in_color, in_color[5:4]};
`else
    assign d = {in_color, 2'b00};
`endif

    assign n1_d     = popcount8(d);
    assign use_xnor = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d[0]);

    always_comb begin
        logic [8:0] q;
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8]    = ~use_xnor;
        qm_next = q;
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            s1_qm <= '0;
            s1_de <= 1'b0;
            s1_c0 <= 1'b0;
            s1_c1 <= 1'b0;
        end else begin
            s1_qm <= qm_next;
            s1_de <= in_de;
            s1_c0 <= in_c0;
            s1_c1 <= in_c1;
        end
    end

    // diff = N1 - N0 = 2*N1 - 8; modulo-32 wrap is harmless since |cnt| stays small
    assign n1_q  = popcount8(s1_qm[7:0]);
    assign diff  = $signed({n1_q, 1'b0}) - 5'sd8;
    assign qm8x2 = {3'b000, s1_qm[8], 1'b0};

    always_comb begin
        sym_next = CTL_00;
        cnt_next = cnt;
        if (!s1_de) begin
            sym_next = ctl_symbol(s1_c1, s1_c0);
            cnt_next = '0;
        end else if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
            sym_next = {~s1_qm[8], s1_qm[8], s1_qm[8] ? s1_qm[7:0] : ~s1_qm[7:0]};
            cnt_next = s1_qm[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
            sym_next = {1'b1, s1_qm[8], ~s1_qm[7:0]};
            cnt_next = cnt + qm8x2 - diff;
        end else begin
            sym_next = {1'b0, s1_qm[8], s1_qm[7:0]};
            cnt_next = cnt + diff - (s1_qm[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            tmds <= CTL_00;
            cnt  <= '0;
        end else begin
            tmds <= sym_next;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/dvi_tmds_encode.sv
// rtl/dvi_tmds_encode.sv - three-channel DVI TMDS encoder: sync polarity and control routing
// Optional macro TMDS_SCALE_REPLICATE_EN (see tmds_chan_enc) selects full-range colour expansion.
module dvi_tmds_encode
    import dvi_pkg::*;
#(
    parameter int COLOR_BITS  = 6,
    parameter bit SYNC_INVERT = 1'b0
) (
    input logic              clk_dot4x,
    input logic              rst_n,
    dvi_tmds_encode_if.slave vid
);

    if (COLOR_BITS != 6) begin : g_bad_color_bits
        $error("dvi_tmds_encode: COLOR_BITS must be 6");
    end

    logic hs, vs;

    assign hs = vid.hsync ^ SYNC_INVERT;
    assign vs = vid.vsync ^ SYNC_INVERT;

    // Only blue carries sync; red and green always send control code 00 in blanking
    tmds_chan_enc u_red (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .color     (vid.red),
        .de        (vid.active),
        .c0        (1'b0),
        .c1        (1'b0),
        .tmds      (vid.tmds_r)
    );

    tmds_chan_enc u_green (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .color     (vid.green),
        .de        (vid.active),
        .c0        (1'b0),
        .c1        (1'b0),
        .tmds      (vid.tmds_g)
    );

    tmds_chan_enc u_blue (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .color     (vid.blue),
        .de        (vid.active),
        .c0        (hs),
        .c1        (vs),
        .tmds      (vid.tmds_b)
    );

endmodule

// File: tb/tb_dvi_tmds_encode.sv
// tb/tb_dvi_tmds_encode.sv - self-checking bench for dvi_tmds_encode against a symbol-level model
module tb_dvi_tmds_encode;
    import dvi_pkg::*;

    logic clk_dot4x = 1'b0;
    logic rst_n     = 1'b0;
    always #5 clk_dot4x = ~clk_dot4x;

    logic [5:0] red = '0, green = '0, blue = '0;
    logic       hsync = 1'b0, vsync = 1'b0, active = 1'b0;

    dvi_tmds_encode_if vif ();
    dvi_tmds_encode_if vif_inv ();

    assign vif.red = red;        assign vif_inv.red = red;
    assign vif.green = green;    assign vif_inv.green = green;
    assign vif.blue = blue;      assign vif_inv.blue = blue;
    assign vif.hsync = hsync;    assign vif_inv.hsync = hsync;
    assign vif.vsync = vsync;    assign vif_inv.vsync = vsync;
    assign vif.active = active;  assign vif_inv.active = active;

    dvi_tmds_encode #(.COLOR_BITS(6), .SYNC_INVERT(1'b0)) dut (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .vid       (vif.slave)
    );

    dvi_tmds_encode #(.COLOR_BITS(6), .SYNC_INVERT(1'b1)) dut_inv (
        .clk_dot4x (clk_dot4x),
        .rst_n     (rst_n),
        .vid       (vif_inv.slave)
    );

    typedef struct {
        logic [9:0] r, g, b, bi;
        bit         de;
        logic [7:0] dr, dg, db;
        bit   [3:0] lm;
        logic [9:0] lr, lg, lb, lbi;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   tests = 0, fails = 0;
    int   mcnt_r = 0, mcnt_g = 0, mcnt_b = 0;
    int   run_r = 0, run_g = 0, run_b = 0;

    function automatic logic [7:0] expand(input logic [5:0] c);
        logic [7:0] v;
`ifdef TMDS_SCALE_REPLICATE_EN
        v = {c, c[5:4]};
`else
        v = {c, 2'b00};
`endif
        return v;
    endfunction

    // Picks the transition encoding, then chooses inversion from the running
    // disparity; the new disparity is simply the ones-minus-zeros of the symbol sent.
    function automatic logic [9:0] enc_model(input logic [7:0] d, input bit de,
                                             input bit [1:0] ctl, input int cin,
                                             output int cout);
        int         ones, n1, n0;
        bit         xn, inv;
        logic [8:0] qm;
        logic [9:0] sym;
        if (!de) begin
            cout = 0;
            case (ctl)
                2'b00:   return 10'h354;
                2'b01:   return 10'h0AB;
                2'b10:   return 10'h154;
                default: return 10'h2AB;
            endcase
        end
        ones  = $countones(d);
        xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (cin == 0 || n1 == n0)                           inv = !qm[8];
        else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) inv = 1'b1;
        else                                                inv = 1'b0;
        sym  = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        cout = cin + 2 * $countones(sym) - 10;
        return sym;
    endfunction

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] t, dd;
        t     = s[9] ? ~s[7:0] : s[7:0];
        dd[0] = t[0];
        for (int i = 1; i < 8; i++) dd[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        return dd;
    endfunction

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic chk_int(input string nm, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push(input bit [3:0] lm, input logic [9:0] lr, input logic [9:0] lg,
                        input logic [9:0] lb, input logic [9:0] lbi);
        exp_t e;
        int   nr, ng, nb, nt;
        e.de = active;
        e.dr = expand(red);
        e.dg = expand(green);
        e.db = expand(blue);
        e.r  = enc_model(e.dr, active, 2'b00, mcnt_r, nr);
        e.g  = enc_model(e.dg, active, 2'b00, mcnt_g, ng);
        e.bi = enc_model(e.db, active, {~vsync, ~hsync}, mcnt_b, nt);
        e.b  = enc_model(e.db, active, {vsync, hsync}, mcnt_b, nb);
        mcnt_r = nr; mcnt_g = ng; mcnt_b = nb;
        e.lm = lm; e.lr = lr; e.lg = lg; e.lb = lb; e.lbi = lbi;
        q.push_back(e);
    endtask

    task automatic set_in(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                          input logic h, input logic v, input logic a);
        red = r; green = g; blue = b; hsync = h; vsync = v; active = a;
    endtask

    task automatic drive(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b,
                         input logic h, input logic v, input logic a, input bit [3:0] lm,
                         input logic [9:0] lr, input logic [9:0] lg, input logic [9:0] lb,
                         input logic [9:0] lbi);
        @(negedge clk_dot4x);
        set_in(r, g, b, h, v, a);
        push(lm, lr, lg, lb, lbi);
    endtask

    task automatic drive_rand(input int pct_active);
        drive(6'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)),
              1'($urandom_range(1)), 1'($urandom_range(1)),
              ($urandom_range(99) < pct_active), 4'b0, '0, '0, '0, '0);
    endtask

    task automatic hold_reset_and_release();
        exp_t pre;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_dot4x);
            set_in(6'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)),
                   1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        @(negedge clk_dot4x);
        rst_n = 1'b1;
        pre = '{r: 10'h354, g: 10'h354, b: 10'h354, bi: 10'h354, de: 1'b0,
                dr: '0, dg: '0, db: '0, lm: 4'hF,
                lr: 10'h354, lg: 10'h354, lb: 10'h354, lbi: 10'h354};
        q.push_back(pre);
        q.push_back(pre);
        set_in(6'h2A, 6'h15, 6'h3F, 1'b1, 1'b1, 1'b1);
        push(4'b0, '0, '0, '0, '0);
    endtask

    task automatic assert_reset();
        @(negedge clk_dot4x);
        rst_n = 1'b0;
        q.delete();
        mcnt_r = 0; mcnt_g = 0; mcnt_b = 0;
        run_r = 0; run_g = 0; run_b = 0;
        #1;
        chk("async_rst_r", vif.tmds_r, 10'h354);
        chk("async_rst_g", vif.tmds_g, 10'h354);
        chk("async_rst_b", vif.tmds_b, 10'h354);
    endtask

    function automatic bit is_ctl(input logic [9:0] s);
        return (s == 10'h354) || (s == 10'h0AB) || (s == 10'h154) || (s == 10'h2AB);
    endfunction

    always begin
        @(posedge clk_dot4x);
        #2;
        if (!rst_n) begin
            chk("rst_r", vif.tmds_r, 10'h354);
            chk("rst_g", vif.tmds_g, 10'h354);
            chk("rst_b", vif.tmds_b, 10'h354);
            chk("rst_b_inv", vif_inv.tmds_b, 10'h354);
        end else if (q.size() > 0) begin
            cur = q.pop_front();
            chk("model_r", vif.tmds_r, cur.r);
            chk("model_g", vif.tmds_g, cur.g);
            chk("model_b", vif.tmds_b, cur.b);
            chk("model_b_inv", vif_inv.tmds_b, cur.bi);
            if (cur.lm[0]) chk("lit_r", vif.tmds_r, cur.lr);
            if (cur.lm[1]) chk("lit_g", vif.tmds_g, cur.lg);
            if (cur.lm[2]) chk("lit_b", vif.tmds_b, cur.lb);
            if (cur.lm[3]) chk("lit_b_inv", vif_inv.tmds_b, cur.lbi);
            if (cur.de) begin
                chk("decode_r", {2'b00, decode(vif.tmds_r)}, {2'b00, cur.dr});
                chk("decode_g", {2'b00, decode(vif.tmds_g)}, {2'b00, cur.dg});
                chk("decode_b", {2'b00, decode(vif.tmds_b)}, {2'b00, cur.db});
                run_r += 2 * $countones(vif.tmds_r) - 10;
                run_g += 2 * $countones(vif.tmds_g) - 10;
                run_b += 2 * $countones(vif.tmds_b) - 10;
                chk_int("disp_r", (run_r >= -8) && (run_r <= 8), run_r, 8);
                chk_int("disp_g", (run_g >= -8) && (run_g <= 8), run_g, 8);
                chk_int("disp_b", (run_b >= -8) && (run_b <= 8), run_b, 8);
            end else begin
                run_r = 0; run_g = 0; run_b = 0;
                chk_int("ctl_r", is_ctl(vif.tmds_r), int'(vif.tmds_r), 'h354);
                chk_int("ctl_b", is_ctl(vif.tmds_b), int'(vif.tmds_b), 'h0AB);
            end
        end
    end

    initial begin
        int c1, c2, c3, c4;
        logic [9:0] s;

        s = enc_model(8'h00, 1'b1, 2'b00, 0, c1);
        chk("pin_zero_first", s, 10'h100);
        chk_int("pin_zero_first_cnt", c1 == -8, c1, -8);
        s = enc_model(8'h00, 1'b1, 2'b00, c1, c2);
        chk("pin_zero_second", s, 10'h3FF);
        chk_int("pin_zero_second_cnt", c2 == 2, c2, 2);
        s = enc_model(8'hFF, 1'b1, 2'b00, 0, c3);
        chk("pin_ff", s, 10'h200);
        chk_int("pin_ff_cnt", c3 == -8, c3, -8);
        s = enc_model(8'h5A, 1'b0, 2'b01, 5, c4);
        chk("pin_ctl01", s, 10'h0AB);

        hold_reset_and_release();

        drive(6'h11, 6'h22, 6'h33, 1'b1, 1'b0, 1'b0, 4'hF, 10'h354, 10'h354, 10'h0AB, 10'h154);
        drive(6'h11, 6'h22, 6'h33, 1'b1, 1'b1, 1'b0, 4'hF, 10'h354, 10'h354, 10'h2AB, 10'h354);
        drive(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 4'hF, 10'h354, 10'h354, 10'h354, 10'h2AB);
        drive(6'h00, 6'h3A, 6'h07, 1'b0, 1'b0, 1'b1, 4'h1, 10'h100, '0, '0, '0);
        drive(6'h00, 6'h19, 6'h2C, 1'b0, 1'b0, 1'b1, 4'h1, 10'h3FF, '0, '0, '0);
        drive(6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, 4'h1, 10'h354, '0, '0, '0);
`ifdef TMDS_SCALE_REPLICATE_EN
        drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 4'h1, 10'h200, '0, '0, '0);
`else
        drive(6'h3F, 6'h00, 6'h00, 1'b0, 1'b0, 1'b1, 4'h0, '0, '0, '0, '0);
`endif
        drive(6'h3F, 6'h3F, 6'h3F, 1'b0, 1'b0, 1'b1, 4'h0, '0, '0, '0, '0);

        for (int i = 0; i < 200; i++) begin
            drive(6'($urandom_range(63)), 6'($urandom_range(63)), 6'($urandom_range(63)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'(i % 2 == 0),
                  4'b0, '0, '0, '0, '0);
        end

        for (int i = 0; i < 20; i++) drive_rand(100);
        assert_reset();
        hold_reset_and_release();

        for (int i = 0; i < 10000; i++) drive_rand((i % 700 < 640) ? 100 : 0);
        for (int i = 0; i < 3; i++) drive_rand(0);

        repeat (3) @(posedge clk_dot4x);
        #4;
        chk_int("queue_drained", q.size() == 0, q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
